// File: rtl/controller.sv
// Main decoder for a single-cycle RV64I datapath: one instruction in, registered controls and immediate out.
// Optional macro CONTROLLER_ITYPE_EN adds decode of the ALU-immediate group (addi/andi/ori).
module controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    output logic [1:0]  ALUControl,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        Branch,
    output logic        MemToReg,
    output logic        ALUScr,
    output logic [63:0] Imm
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    function automatic logic [63:0] imm_i(input logic [31:0] ins);
        return {{52{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [63:0] imm_s(input logic [31:0] ins);
        return {{52{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [63:0] imm_b(input logic [31:0] ins);
        return {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    // rs1 never influences decode or any immediate format handled here.
    logic        unused_rs1_s;

    assign opcode_s     = Instruction[6:0];
    assign funct3_s     = Instruction[14:12];
    assign funct7_s     = Instruction[31:25];
    assign unused_rs1_s = ^Instruction[19:15];

    logic [1:0]  alu_ctrl_d, alu_ctrl_q;
    logic        reg_write_d, reg_write_q;
    logic        mem_write_d, mem_write_q;
    logic        branch_d, branch_q;
    logic        mem_to_reg_d, mem_to_reg_q;
    logic        alu_src_d, alu_src_q;
    logic [63:0] imm_d, imm_q;

    // Combinational decode; anything not matched leaves the all-zero (no side effect) default.
    always_comb begin
        alu_ctrl_d   = ALU_ADD;
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_d    = 1'b0;
        imm_d        = 64'd0;
        case (opcode_s)
            OP_LOAD: begin
                if (funct3_s == 3'b011) begin
                    reg_write_d  = 1'b1;
                    mem_to_reg_d = 1'b1;
                    alu_src_d    = 1'b1;
                    imm_d        = imm_i(Instruction);
                end else begin
                    imm_d = 64'd0;
                end
            end
            OP_STORE: begin
                if (funct3_s == 3'b011) begin
                    mem_write_d = 1'b1;
                    alu_src_d   = 1'b1;
                    imm_d       = imm_s(Instruction);
                end else begin
                    imm_d = 64'd0;
                end
            end
            OP_REG: begin
                case ({funct7_s, funct3_s})
                    {7'b0000000, 3'b000}: begin reg_write_d = 1'b1; alu_ctrl_d = ALU_ADD; end
                    {7'b0100000, 3'b000}: begin reg_write_d = 1'b1; alu_ctrl_d = ALU_SUB; end
                    {7'b0000000, 3'b111}: begin reg_write_d = 1'b1; alu_ctrl_d = ALU_AND; end
                    {7'b0000000, 3'b110}: begin reg_write_d = 1'b1; alu_ctrl_d = ALU_OR;  end
                    default:              begin reg_write_d = 1'b0; alu_ctrl_d = ALU_ADD; end
                endcase
            end
            OP_BRANCH: begin
                if (funct3_s == 3'b000) begin
                    branch_d   = 1'b1;
                    alu_ctrl_d = ALU_SUB;
                    imm_d      = imm_b(Instruction);
                end else begin
                    imm_d = 64'd0;
                end
            end
`ifdef CONTROLLER_ITYPE_EN
            OP_IMM: begin
                case (funct3_s)
                    3'b000:  begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_ctrl_d = ALU_ADD; imm_d = imm_i(Instruction); end
                    3'b111:  begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_ctrl_d = ALU_AND; imm_d = imm_i(Instruction); end
                    3'b110:  begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_ctrl_d = ALU_OR;  imm_d = imm_i(Instruction); end
                    default: begin reg_write_d = 1'b0; alu_src_d = 1'b0; alu_ctrl_d = ALU_ADD; imm_d = 64'd0; end
                endcase
            end
`else
            OP_IMM: begin
                imm_d = 64'd0;
            end
`endif
            default: begin
                imm_d = 64'd0;
            end
        endcase
    end

    // Output register with synchronous clear taking priority over decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl_q   <= ALU_ADD;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            imm_q        <= 64'd0;
        end else begin
            alu_ctrl_q   <= alu_ctrl_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_q    <= alu_src_d;
            imm_q        <= imm_d;
        end
    end

    assign ALUControl = alu_ctrl_q;
    assign RegWrite   = reg_write_q;
    assign MemWrite   = mem_write_q;
    assign Branch     = branch_q;
    assign MemToReg   = mem_to_reg_q;
    assign ALUScr     = alu_src_q;
    assign Imm        = imm_q;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: expected control words are queued at drive time and checked one edge later.
module tb_controller;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction;
    logic [1:0]  ALUControl;
    logic        RegWrite, MemWrite, Branch, MemToReg, ALUScr;
    logic [63:0] Imm;

    typedef logic [70:0] ctl_t;

    ctl_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    controller dut (
        .clk         (clk),
        .rst         (rst),
        .Instruction (Instruction),
        .ALUControl  (ALUControl),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .Branch      (Branch),
        .MemToReg    (MemToReg),
        .ALUScr      (ALUScr),
        .Imm         (Imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {ALUControl, RegWrite, MemWrite, Branch, MemToReg, ALUScr, Imm}.
    function automatic ctl_t mk(input logic [1:0] alu, input logic rw, input logic mw, input logic br,
                                input logic m2r, input logic src, input logic [63:0] imm);
        return {alu, rw, mw, br, m2r, src, imm};
    endfunction

    task automatic check_ctl(input string tag, input ctl_t obs, input ctl_t exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got alu=%b rw=%b mw=%b br=%b m2r=%b src=%b imm=%h, expected alu=%b rw=%b mw=%b br=%b m2r=%b src=%b imm=%h",
                     tag, obs[70:69], obs[68], obs[67], obs[66], obs[65], obs[64], obs[63:0],
                     exp[70:69], exp[68], exp[67], exp[66], exp[65], exp[64], exp[63:0]);
        end
    endtask

    // Checks the word produced by the previous edge, then drives the next stimulus.
    task automatic apply(input string tag, input logic r, input logic [31:0] ins, input ctl_t e);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            check_ctl(tag_q.pop_front(), {ALUControl, RegWrite, MemWrite, Branch, MemToReg, ALUScr, Imm},
                      exp_q.pop_front());
        end
        rst         = r;
        Instruction = ins;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    ctl_t ZERO;

    initial begin
        logic [4:0] rd, rs1, rs2;
        ZERO        = 71'd0;
        rst         = 1'b1;
        Instruction = 32'h0000_0000;

        apply("rst_edge0", 1'b1, 32'h36A33503, ZERO);
        apply("rst_edge1", 1'b1, 32'hFFFFFFFF, ZERO);

        apply("ld",        1'b0, 32'h36A33503, mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_036A));
        apply("ld_neg1",   1'b0, 32'hFFF33503, mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF));
        apply("ld_min",    1'b0, 32'h80033503, mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_F800));
        apply("sd",        1'b0, 32'h36A33523, mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_036A));
        apply("sd_neg1",   1'b0, 32'hFE533FA3, mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF));
        apply("add",       1'b0, 32'h00A30533, mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0));
        apply("sub",       1'b0, 32'h40A30533, mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0));
        apply("and",       1'b0, 32'h00A37533, mk(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0));
        apply("or",        1'b0, 32'h00A36533, mk(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0));
        apply("beq",       1'b0, 32'h14A30563, mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_014A));
        apply("beq_neg4",  1'b0, 32'hFE000EE3, mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC));

        // Encodings that sit next to legal ones but must decode to nothing.
        apply("xor_ill",   1'b0, 32'h00A34533, ZERO);
        apply("lw_ill",    1'b0, 32'h36A32503, ZERO);
        apply("sw_ill",    1'b0, 32'h36A32523, ZERO);
        apply("mul_ill",   1'b0, 32'h02A30533, ZERO);
        apply("subf3_ill", 1'b0, 32'h40A37533, ZERO);
        apply("bne_ill",   1'b0, 32'h14A31563, ZERO);
        apply("lui_ill",   1'b0, 32'h123452B7, ZERO);
        apply("slti_ill",  1'b0, 32'h00532513, ZERO);

`ifdef CONTROLLER_ITYPE_EN
        apply("addi",      1'b0, 32'h00530513, mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0005));
        apply("andi",      1'b0, 32'h00537513, mk(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0005));
        apply("ori_neg",   1'b0, 32'hFFF36513, mk(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF));
`else
        apply("addi_off",  1'b0, 32'h00530513, ZERO);
        apply("andi_off",  1'b0, 32'h00537513, ZERO);
`endif

        // Reset in mid-stream overrides a legal instruction, then decode resumes.
        apply("rst_mid",   1'b1, 32'h00A30533, ZERO);
        apply("post_rst",  1'b0, 32'h40A30533, mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0));

        // Register fields must not affect decode.
        for (int i = 0; i < 8; i++) begin
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            apply("sub_rand", 1'b0, {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011},
                  mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0));
        end

        apply("tail_hold", 1'b0, 32'h00000000, ZERO);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            check_ctl(tag_q.pop_front(), {ALUControl, RegWrite, MemWrite, Branch, MemToReg, ALUScr, Imm},
                      exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
